mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle sequencing controller for the MIPS subset add, sub, ori, lw, sw, beq, lui, jal, jr.
- Replaces the single-cycle decode. Drives PC, IR, register file, ALU, extender and unified memory one state per cycle.
- Waits on a memory ready handshake and carries a memory-timeout watchdog.
- Sits between the instruction register (op/func come from the IR) and the shared datapath.

Parameters:
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before a bus error.
- CNT_W, 5, width of the wait counter. Must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- zero  in  1  ALU equal flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_we  out  1  PC write enable.
- pc_src  out  2  PC source select:
  - 00 PC+4
  - 01 branch target
  - 10 jump target
  - 11 rs (jr)
- ir_we  out  1  IR write enable.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write (valid only with mem_req).
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- regwrite  out  1  register file write enable.
- regdst  out  2  write register select: 00 rt, 01 rd, 10 $31.
- memtoreg  out  2  write data select: 00 ALU, 01 MDR, 10 PC+4.
- alusrc  out  1  ALU B select: 0 = rt, 1 = extended immediate.
- extop  out  2  extender mode: 00 zero, 01 sign, 10 lui shift.
- aluctr  out  3  ALU operation: 000 add, 001 sub, 010 or.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- bus_err  out  1  sticky timeout flag.
- state_o  out  3  current state, for debug.

Behaviour:
- Reset:
  - Asynchronous on reset_n low. State = FETCH; wait counter = 0.
  - All registered flags clear, including bus_err.
  - Outputs are Moore/Mealy combinational from state. With state FETCH and mem_ready low, all outputs are 0 except mem_req = 1.
  - Releasing reset begins a fetch on the next edge.
- Datapath-mode outputs (regdst, memtoreg, alusrc, extop, aluctr) are decoded from op/func in every state. Non-listed instructions decode to all zeros.
- Enables (pc_we, ir_we, regwrite, mem_*) are asserted only in the states below. They are 0 everywhere else.
- FETCH:
  - mem_req = 1, iord = 0.
  - On mem_ready: ir_we = 1, pc_we = 1, pc_src = 00, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Known instruction -> EXEC.
  - Unknown op/func -> FETCH with instr_done = 1 (treated as nop).
- EXEC:
  - beq: pc_we = zero, pc_src = 01, instr_done = 1 -> FETCH.
  - jal: regwrite = 1, regdst = 10, memtoreg = 10, pc_we = 1, pc_src = 10, instr_done = 1 -> FETCH.
  - jr: pc_we = 1, pc_src = 11, instr_done = 1, regwrite = 0 -> FETCH.
  - lw, sw -> MEM.
  - add, sub, ori, lui -> WB.
- MEM:
  - mem_req = 1, iord = 1, mem_we = sw.
  - On mem_ready: lw -> WB; sw -> FETCH with instr_done = 1.
- WB: regwrite = 1, instr_done = 1 -> FETCH.
- Latency with mem_ready tied high:
  - beq, jal, jr: 3 cycles.
  - add, sub, ori, lui, sw: 4 cycles.
  - lw: 5 cycles.
- Wait counter and timeout:
  - Counter clears on entry to FETCH or MEM and on mem_ready. It increments on each cycle with mem_req = 1 and mem_ready = 0.
  - When it reaches TIMEOUT: bus_err is set, state goes to HALT.
  - HALT: all enables 0, mem_req = 0. Stays in HALT until reset.
- mem_ready arriving while in a non-memory state is ignored.
- op/func must be stable from DECODE until the instruction ends. The IR guarantees this because ir_we is asserted only in FETCH.
- Reset mid-instruction aborts immediately. No partial register or memory write occurs after reset_n falls.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown instruction in DECODE goes to TRAP, asserting output illegal = 1 (extra 1-bit port).
  - TRAP holds all enables 0 until reset.
- Undefined:
  - The illegal port is absent. Unknown instructions retire as a nop (DECODE -> FETCH).

Decomposition:
- Package mc_pkg holds:
  - Opcode constants: OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_JAL.
  - Funct constants: FN_ADD, FN_SUB, FN_JR.
  - ALU / ext / mux select codes.
  - State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- One sub-module: mc_decode. Combinational decode of op/func into the instruction class and the mode outputs. The FSM, counter and enable logic stay in mc_control.

Test Plan:
- add (op=0, func=0x20), mem_ready=1 -> states FETCH, DECODE, EXEC, WB. regwrite=1 with regdst=01 in cycle 4 only. instr_done in cycle 4.
- lw (op=0x23) with mem_ready low for 3 cycles in MEM -> mem_req, iord=1 held 4 cycles. WB follows. Total 8 cycles. extop=01.
- beq (op=0x04), zero=0 then zero=1 -> pc_we=0 then pc_we=1 with pc_src=01 in EXEC. Both take 3 cycles.
- jal (op=0x03) then jr (op=0, func=0x08):
  - jal: regwrite=1, regdst=10, memtoreg=10, pc_src=10.
  - jr: pc_src=11, regwrite=0.
- mem_ready held low in FETCH -> after 16 cycles bus_err=1, HALT, mem_req=0. reset_n low clears bus_err and returns to FETCH.
- reset_n pulsed low during MEM of sw -> mem_we drops asynchronously. State is FETCH after release. With MC_ILLEGAL_TRAP_EN, op=0x3F -> illegal=1.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multi-cycle MIPS-subset controller.
//   - opcode / funct constants for add, sub, ori, lw, sw, beq, lui, jal, jr
//   - ALU, extender, PC-source, write-register and write-data select codes
//   - FSM state encoding (FETCH=0 .. TRAP=6)
//   - instruction class enum and datapath-mode struct produced by mc_decode
package mc_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct codes (IR[5:0]) for R-type
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    // ALU operation
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    // Extender mode
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // PC source
    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_JMP   = 2'b10;
    localparam logic [1:0] PC_RS    = 2'b11;

    // Write register select
    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    // Write data select
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MDR   = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    // FSM state encoding
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    typedef enum logic [3:0] {
        IC_NONE,
        IC_ADD,
        IC_SUB,
        IC_ORI,
        IC_LW,
        IC_SW,
        IC_BEQ,
        IC_LUI,
        IC_JAL,
        IC_JR
    } iclass_t;

    typedef struct packed {
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrc;
        logic [1:0] extop;
        logic [2:0] aluctr;
    } mode_t;

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: unified-memory handshake between the controller and memory.
//   mem_req   : access request (controller -> memory)
//   mem_we    : write strobe, meaningful only with mem_req
//   iord      : address select, 0 = PC, 1 = ALU result
//   mem_ready : memory completes the current access this cycle
// Modports: master = controller side, slave = memory side.
interface mc_control_if;

    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  iord,
        output mem_ready
    );

endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational decode of IR op/func into an instruction class
// and the datapath-mode selects (regdst, memtoreg, alusrc, extop, aluctr).
//   op_i, func_i : IR[31:26], IR[5:0]
//   iclass_o     : instruction class, IC_NONE for anything outside the subset
//   mode_o       : mode selects, all zero for IC_NONE
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output iclass_t    iclass_o,
    output mode_t      mode_o
);

    always_comb begin
        iclass_o = IC_NONE;
        unique case (op_i)
            OP_RTYPE: begin
                unique case (func_i)
                    FN_ADD:  iclass_o = IC_ADD;
                    FN_SUB:  iclass_o = IC_SUB;
                    FN_JR:   iclass_o = IC_JR;
                    default: iclass_o = IC_NONE;
                endcase
            end
            OP_ORI:  iclass_o = IC_ORI;
            OP_LW:   iclass_o = IC_LW;
            OP_SW:   iclass_o = IC_SW;
            OP_BEQ:  iclass_o = IC_BEQ;
            OP_LUI:  iclass_o = IC_LUI;
            OP_JAL:  iclass_o = IC_JAL;
            default: iclass_o = IC_NONE;
        endcase
    end

    always_comb begin
        mode_o = '0;
        case (iclass_o)
            IC_ADD: begin
                mode_o.regdst = RD_RD;
                mode_o.aluctr = ALU_ADD;
            end
            IC_SUB: begin
                mode_o.regdst = RD_RD;
                mode_o.aluctr = ALU_SUB;
            end
            IC_ORI: begin
                mode_o.alusrc = 1'b1;
                mode_o.extop  = EXT_ZERO;
                mode_o.aluctr = ALU_OR;
            end
            IC_LW: begin
                mode_o.memtoreg = WD_MDR;
                mode_o.alusrc   = 1'b1;
                mode_o.extop    = EXT_SIGN;
                mode_o.aluctr   = ALU_ADD;
            end
            IC_SW: begin
                mode_o.alusrc = 1'b1;
                mode_o.extop  = EXT_SIGN;
                mode_o.aluctr = ALU_ADD;
            end
            IC_BEQ: begin
                // sign-extended offset feeds the branch target adder
                mode_o.extop  = EXT_SIGN;
                mode_o.aluctr = ALU_SUB;
            end
            IC_LUI: begin
                // rs is $0 for lui, so add passes the shifted immediate through
                mode_o.alusrc = 1'b1;
                mode_o.extop  = EXT_LUI;
                mode_o.aluctr = ALU_ADD;
            end
            IC_JAL: begin
                mode_o.regdst   = RD_RA;
                mode_o.memtoreg = WD_PC4;
            end
            default: mode_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle sequencing controller for add, sub, ori, lw, sw,
// beq, lui, jal, jr. One FSM state per cycle drives PC, IR, register file,
// ALU, extender and the unified memory, with a memory-timeout watchdog.
//   clk, reset_n   : clock (rising edge), asynchronous active-low reset
//   op, func, zero : IR fields and ALU equal flag
//   mem            : memory handshake (mc_control_if.master)
//   pc_we, pc_src, ir_we, regwrite : sequencing enables / PC source
//   regdst, memtoreg, alusrc, extop, aluctr : datapath modes from op/func
//   instr_done     : pulse on the last cycle of every instruction
//   bus_err        : sticky memory-timeout flag
//   illegal        : in TRAP state (present only with MC_ILLEGAL_TRAP_EN)
//   state_o        : current FSM state
// Build option: define MC_ILLEGAL_TRAP_EN to trap unknown instructions in TRAP
// instead of retiring them as a nop.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        zero,
    mc_control_if.master mem,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic        regwrite,
    output logic [1:0]  regdst,
    output logic [1:0]  memtoreg,
    output logic        alusrc,
    output logic [1:0]  extop,
    output logic [2:0]  aluctr,
    output logic        instr_done,
    output logic        bus_err,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [2:0]  state_o
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    iclass_t iclass;
    mode_t   mode;

    logic mem_req_c;
    logic mem_we_c;
    logic iord_c;

    mc_decode u_decode (
        .op_i     (op),
        .func_i   (func),
        .iclass_o (iclass),
        .mode_o   (mode)
    );

    // Sequencing and enables
    always_comb begin
        state_d    = state_q;
        pc_we      = 1'b0;
        pc_src     = PC_SEQ;
        ir_we      = 1'b0;
        regwrite   = 1'b0;
        instr_done = 1'b0;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        iord_c     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (iclass != IC_NONE) begin
                    state_d = ST_EXEC;
                end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
`endif
                end
            end
            ST_EXEC: begin
                case (iclass)
                    IC_BEQ: begin
                        pc_we      = zero;
                        pc_src     = PC_BR;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    IC_JAL: begin
                        regwrite   = 1'b1;
                        pc_we      = 1'b1;
                        pc_src     = PC_JMP;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    IC_JR: begin
                        pc_we      = 1'b1;
                        pc_src     = PC_RS;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    IC_LW, IC_SW: state_d = ST_MEM;
                    IC_ADD, IC_SUB, IC_ORI, IC_LUI: state_d = ST_WB;
                    default: begin
                        // op/func are held by the IR, so this only covers a
                        // class change that should never happen; retire safely
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                mem_we_c  = (iclass == IC_SW);
                if (mem.mem_ready) begin
                    if (iclass == IC_SW) begin
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT, ST_TRAP: state_d = state_q;
            default: state_d = ST_FETCH;
        endcase

        // Watchdog: counts consecutive request cycles without ready. It is
        // zero whenever no request is pending, which covers clearing on entry
        // to FETCH/MEM; the last allowed stall cycle diverts to HALT.
        cnt_d     = '0;
        bus_err_d = bus_err_q;
        if (mem_req_c && !mem.mem_ready) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                bus_err_d = 1'b1;
                state_d   = ST_HALT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign mem.mem_req = mem_req_c;
    assign mem.mem_we  = mem_we_c;
    assign mem.iord    = iord_c;

    assign regdst   = mode.regdst;
    assign memtoreg = mode.memtoreg;
    assign alusrc   = mode.alusrc;
    assign extop    = mode.extop;
    assign aluctr   = mode.aluctr;

    assign bus_err = bus_err_q;
    assign state_o = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = (state_q == ST_TRAP);
`endif

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: random instruction stream with random
// memory stalls, checked per retired instruction against an instruction-level
// model; plus reset, timeout, async-reset-in-MEM and (optionally) trap checks.
module tb_mc_control;

    localparam int TMO = 16;

    // Bench-local ISA constants
    localparam logic [5:0] B_RT = 6'h00, B_ORI = 6'h0D, B_LW = 6'h23, B_SW = 6'h2B;
    localparam logic [5:0] B_BEQ = 6'h04, B_LUI = 6'h0F, B_JAL = 6'h03;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_JR = 6'h08;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'h3F, func = 6'h00;
    logic       zero = 1'b0;
    logic       pc_we, ir_we, regwrite, alusrc, instr_done, bus_err;
    logic [1:0] pc_src, regdst, memtoreg, extop;
    logic [2:0] aluctr, state_o;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    mc_control_if mif ();

    mc_control #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .func       (func),
        .zero       (zero),
        .mem        (mif),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .ir_we      (ir_we),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrc     (alusrc),
        .extop      (extop),
        .aluctr     (aluctr),
        .instr_done (instr_done),
        .bus_err    (bus_err),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal    (illegal),
`endif
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic       zero;
        int         fs;   // fetch stall cycles
        int         ms;   // data-access stall cycles
    } ins_t;

    typedef struct {
        int         lat, irw, pcw, rw, mwe, dcyc, fcyc;
        logic [1:0] psrc, rdst, m2r, ext;
        logic       asrc;
        logic [2:0] alu;
    } exp_t;

    ins_t nq[$];
    exp_t sbq[$];
    ins_t cur;
    int   errors = 0;
    int   checks = 0;
    bit   auto_run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference: what each instruction does over its lifetime.
    function automatic exp_t model(input ins_t i);
        exp_t e;
        e = '{lat: i.fs + 2, irw: 1, pcw: 1, rw: 0, mwe: 0, dcyc: 0, fcyc: i.fs + 1,
              psrc: 2'd0, rdst: 2'd0, m2r: 2'd0, ext: 2'd0, asrc: 1'b0, alu: 3'd0};
        if (i.op == B_RT && (i.func == F_ADD || i.func == F_SUB)) begin
            e.lat += 2; e.rw = 1; e.rdst = 2'd1;
            e.alu = (i.func == F_SUB) ? 3'd1 : 3'd0;
        end else if (i.op == B_RT && i.func == F_JR) begin
            e.lat += 1; e.pcw = 2; e.psrc = 2'd3;
        end else if (i.op == B_ORI) begin
            e.lat += 2; e.rw = 1; e.asrc = 1'b1; e.alu = 3'd2;
        end else if (i.op == B_LUI) begin
            e.lat += 2; e.rw = 1; e.asrc = 1'b1; e.ext = 2'd2;
        end else if (i.op == B_LW) begin
            e.lat += 1 + (i.ms + 1) + 1; e.rw = 1; e.m2r = 2'd1;
            e.asrc = 1'b1; e.ext = 2'd1; e.dcyc = i.ms + 1;
        end else if (i.op == B_SW) begin
            e.lat += 1 + (i.ms + 1); e.asrc = 1'b1; e.ext = 2'd1;
            e.dcyc = i.ms + 1; e.mwe = i.ms + 1;
        end else if (i.op == B_BEQ) begin
            e.lat += 1; e.ext = 2'd1; e.alu = 3'd1; e.psrc = 2'd1;
            e.pcw = 1 + int'(i.zero);
        end else if (i.op == B_JAL) begin
            e.lat += 1; e.rw = 1; e.rdst = 2'd2; e.m2r = 2'd2; e.pcw = 2; e.psrc = 2'd2;
        end
        return e;
    endfunction

    task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int fs, input int ms);
        ins_t i;
        i = '{op: o, func: f, zero: z, fs: fs, ms: ms};
        nq.push_back(i);
        sbq.push_back(model(i));
    endtask

    // Driver: memory model answering after the instruction's stall count, and
    // an IR model loading the next instruction whenever ir_we is seen.
    initial begin : drv
        int wcnt;
        int need;
        bit load;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!auto_run) begin
                wcnt = 0;
            end else begin
                if (mif.mem_req) begin
                    need = mif.iord ? cur.ms : ((nq.size() > 0) ? nq[0].fs : 1000);
                    mif.mem_ready = (wcnt >= need);
                end else begin
                    mif.mem_ready = 1'($urandom_range(0, 1));
                end
                #1;
                load = ir_we;
                if (mif.mem_req) wcnt = mif.mem_ready ? 0 : wcnt + 1;
                @(posedge clk);
                #1;
                if (load && nq.size() > 0) begin
                    cur  = nq.pop_front();
                    op   = cur.op;
                    func = cur.func;
                    zero = cur.zero;
                end
            end
        end
    end

    // Monitor: accumulate per-instruction activity, compare on instr_done.
    initial begin : mon
        int cyc, irw, pcw, rw, mwe, dcyc, fcyc;
        exp_t e;
        cyc = 0; irw = 0; pcw = 0; rw = 0; mwe = 0; dcyc = 0; fcyc = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!auto_run) begin
                cyc = 0; irw = 0; pcw = 0; rw = 0; mwe = 0; dcyc = 0; fcyc = 0;
            end else begin
                cyc++;
                irw  += int'(ir_we);
                pcw  += int'(pc_we);
                rw   += int'(regwrite);
                mwe  += int'(mif.mem_req & mif.mem_we);
                dcyc += int'(mif.mem_req & mif.iord);
                fcyc += int'(mif.mem_req & ~mif.iord);
                if (instr_done) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("latency",    cyc,  e.lat);
                        chk("ir_we_cnt",  irw,  e.irw);
                        chk("pc_we_cnt",  pcw,  e.pcw);
                        chk("pc_src",     pc_src, e.psrc);
                        chk("regwr_cnt",  rw,   e.rw);
                        chk("regdst",     regdst, e.rdst);
                        chk("memtoreg",   memtoreg, e.m2r);
                        chk("alusrc",     alusrc, e.asrc);
                        chk("extop",      extop, e.ext);
                        chk("aluctr",     aluctr, e.alu);
                        chk("memwe_cnt",  mwe,  e.mwe);
                        chk("data_cyc",   dcyc, e.dcyc);
                        chk("fetch_cyc",  fcyc, e.fcyc);
                        chk("bus_err_run", bus_err, 0);
                    end
                    cyc = 0; irw = 0; pcw = 0; rw = 0; mwe = 0; dcyc = 0; fcyc = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int n;
        int k;
        bit done;
        mif.mem_ready = 1'b0;

        // Reset state: FETCH, only mem_req high (op decodes to nothing)
        #12;
        chk("rst_state",  state_o, 0);
        chk("rst_memreq", mif.mem_req, 1);
        chk("rst_others", {pc_we, pc_src, ir_we, mif.mem_we, mif.iord, regwrite, regdst,
                           memtoreg, alusrc, extop, aluctr, instr_done, bus_err}, 0);

        // Directed sequences first, then random stream
        issue(B_RT,  F_ADD, 1'b0, 0, 0);
        issue(B_LW,  6'h11, 1'b0, 0, 3);
        issue(B_BEQ, 6'h00, 1'b0, 0, 0);
        issue(B_BEQ, 6'h00, 1'b1, 0, 0);
        issue(B_JAL, 6'h20, 1'b0, 0, 0);
        issue(B_RT,  F_JR,  1'b0, 0, 0);
        issue(B_SW,  6'h00, 1'b0, 0, 0);
        issue(B_RT,  F_ADD, 1'b0, TMO - 1, 0);
        issue(B_SW,  6'h00, 1'b0, 2, TMO - 1);
        for (int j = 0; j < 70; j++) begin
            logic [5:0] o, f;
            int fs, ms;
            f  = 6'($urandom_range(0, 63));
            fs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 3);
            ms = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 3);
            k  = $urandom_range(0, 9);
            case (k)
                0: begin o = B_RT; f = F_ADD; end
                1: begin o = B_RT; f = F_SUB; end
                2: o = B_ORI;
                3: o = B_LW;
                4: o = B_SW;
                5: o = B_BEQ;
                6: o = B_LUI;
                7: o = B_JAL;
                8: begin o = B_RT; f = F_JR; end
                default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                    o = B_ORI;
`else
                    if (f[0]) o = 6'h3F;
                    else begin o = B_RT; f = 6'h25; end
`endif
                end
            endcase
            issue(o, f, 1'($urandom_range(0, 1)), fs, ms);
        end

        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        auto_run = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            #3;
            if (sbq.size() == 0) done = 1'b1;
        end
        auto_run = 1'b0;
        chk("stream_drained", sbq.size(), 0);

        // Timeout: fetch never answered
        @(negedge clk);
        reset_n = 1'b0;
        mif.mem_ready = 1'b0;
        op = 6'h3F; func = 6'h00;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (state_o == 3'd5) break;
            n++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_state",  state_o, 5);
        chk("tmo_buserr", bus_err, 1);
        chk("tmo_memreq", mif.mem_req, 0);
        mif.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("halt_hold",  state_o, 5);
        chk("halt_enables", {pc_we, ir_we, regwrite, mif.mem_req, mif.mem_we, instr_done}, 0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_clr_buserr", bus_err, 0);
        chk("rst_clr_state",  state_o, 0);

        // Reset while sw is in MEM
        mif.mem_ready = 1'b0;
        op = B_SW; func = 6'h00;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        mif.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mif.mem_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (state_o == 3'd3) break;
        end
        chk("sw_in_mem", state_o, 3);
        chk("sw_memwe",  mif.mem_we, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("sw_rst_memwe", mif.mem_we, 0);
        chk("sw_rst_state", state_o, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("sw_rel_state", state_o, 0);

`ifdef MC_ILLEGAL_TRAP_EN
        // Unknown instruction traps
        op = 6'h3F;
        @(negedge clk);
        mif.mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("trap_state",   state_o, 6);
        chk("trap_illegal", illegal, 1);
        chk("trap_enables", {pc_we, ir_we, regwrite, mif.mem_req, mif.mem_we}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
